// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C arbiter.
// Optional build macro used by i2c_arbiter: I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_COMPLETE   = 3'd4
    } arb_state_t;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int BYTES_W = 4;

    // Packed command word: {rw, address, data, bytesend}
    localparam int CTL_FIELD_W = 1 + ADDR_W + DATA_W + BYTES_W;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches the request vector starting
// one past the previous winner, wrapping around, and reports the first hit.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest candidate back to last+1 so the nearest hit wins.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last) + k) % N_REQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C controller among N_REQ requesters.
// Optional build macro: I2C_ARB_TIMEOUT_EN adds start/busy timeouts that
// complete the transaction with o_req_err=1.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | waiting for any request; grant and latch on the edge
// ST_ISSUE      | ctl_init pulse to the controller
// ST_WAIT_START | waiting for controller busy to rise
// ST_WAIT_DONE  | waiting for controller busy to fall
// ST_COMPLETE   | done pulse to the granted requester (with error flag)
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int START_WAIT     = 15,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ-1:0]           i_req_rw,
    input  logic [ADDR_W*N_REQ-1:0]    i_req_addr,
    input  logic [DATA_W*N_REQ-1:0]    i_req_data,
    input  logic [BYTES_W*N_REQ-1:0]   i_req_bytes,
    output logic [N_REQ-1:0]           o_req_done,
    output logic                       o_req_err,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_arb_busy,
    output logic                       o_ctl_init,
    output logic                       o_ctl_rw,
    output logic [ADDR_W-1:0]          o_ctl_address,
    output logic [DATA_W-1:0]          o_ctl_data,
    output logic [BYTES_W-1:0]         o_ctl_bytesend,
    input  logic                       i_ctl_busy
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       r_grant_id;
    logic [CTL_FIELD_W-1:0] r_ctl_fields;
    logic [CTL_FIELD_W-1:0] w_sel_fields;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_timeout_hit;
    logic                   w_err_flag;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req    (i_req_valid),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_sel_fields = {i_req_rw[w_winner],
                           i_req_addr[int'(w_winner)*ADDR_W +: ADDR_W],
                           i_req_data[int'(w_winner)*DATA_W +: DATA_W],
                           i_req_bytes[int'(w_winner)*BYTES_W +: BYTES_W]};

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(max_int(START_WAIT, TIMEOUT_CYCLES) + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    assign w_timeout_hit = ((r_state == ST_WAIT_START) && (r_wait_cnt >= CNT_W'(START_WAIT))) ||
                           ((r_state == ST_WAIT_DONE)  && (r_wait_cnt >= CNT_W'(TIMEOUT_CYCLES)));
    assign w_err_flag    = r_err;

    // Wait counter restarts on every state entry and saturates; error latches on a timed-out exit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state != w_state_next) begin
                r_wait_cnt <= '0;
            end else if (((r_state == ST_WAIT_START) || (r_state == ST_WAIT_DONE)) &&
                         (r_wait_cnt != '1)) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_grant) begin
                r_err <= 1'b0;
            end else if (w_timeout_hit &&
                         (((r_state == ST_WAIT_START) && !i_ctl_busy) ||
                          ((r_state == ST_WAIT_DONE)  &&  i_ctl_busy))) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_timeout_hit = 1'b0;
    assign w_err_flag    = 1'b0;
    assign w_unused_cfg  = START_WAIT[0] ^ TIMEOUT_CYCLES[0];
`endif

    // State register plus grant-time capture of winner index and command fields.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last       <= IDX_W'(N_REQ - 1);
            r_grant_id   <= '0;
            r_ctl_fields <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_last       <= w_winner;
                r_grant_id   <= w_winner;
                r_ctl_fields <= w_sel_fields;
            end
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        o_ctl_init   = 1'b0;
        o_arb_busy   = 1'b1;
        o_req_done   = '0;
        o_req_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_arb_busy = 1'b0;
                if (w_any) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_ctl_init   = 1'b1;
                w_state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (i_ctl_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (w_timeout_hit) begin
                    w_state_next = ST_COMPLETE;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_ctl_busy || w_timeout_hit) begin
                    w_state_next = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                o_req_done   = N_REQ'(1) << r_grant_id;
                o_req_err    = w_err_flag;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_grant_id = r_grant_id;
    assign {o_ctl_rw, o_ctl_address, o_ctl_data, o_ctl_bytesend} = r_ctl_fields;

endmodule
